uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receive path with a 2-flop input
// synchronizer, a start/data/stop framing FSM and a one-deep output
// holding register with sticky error flags.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// between the data bits and the stop bit (adds the PARITY state).
module uart_receiver #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 uart_tick_16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    input  logic                 data_ack,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 parity_error,
    output logic                 busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   sync1_q, sync1_d;
    logic                   rx_s_q, rx_s_d;
    logic                   prev_q, prev_d;
    logic [DATA_BITS-1:0]   data_out_q, data_out_d;
    logic                   data_ready_q, data_ready_d;
    logic                   frame_error_q, frame_error_d;
    logic                   overrun_q, overrun_d;
    logic                   parity_error_q, parity_error_d;
    logic                   accept;

    // Next-state, sampling and output-register logic; ticks gate all framing progress.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        sync1_d        = rx;
        rx_s_d         = sync1_q;
        prev_d         = prev_q;
        data_out_d     = data_out_q;
        data_ready_d   = data_ready_q;
        frame_error_d  = frame_error_q;
        overrun_d      = overrun_q;
        parity_error_d = parity_error_q;
        accept         = 1'b0;

        // A read strobe clears the holding register and every sticky flag;
        // events later in this cycle take priority over the clear.
        if (data_ack) begin
            data_ready_d   = 1'b0;
            frame_error_d  = 1'b0;
            overrun_d      = 1'b0;
            parity_error_d = 1'b0;
        end

        if (uart_tick_16) begin
            // prev_q remembers rx_s at the previous tick; after a break it
            // stays low until the line is seen high again, blocking false starts.
            prev_d = rx_s_q;
            cnt_d  = cnt_q + 4'd1;
            case (state_q)
                IDLE: begin
                    cnt_d = 4'd0;
                    if (!rx_s_q && prev_q) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d     = 4'd0;
                        bit_idx_d = 3'd0;
                        state_d   = rx_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == 4'd15) begin
                        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == 4'd15) begin
                        if (rx_s_q != (^shift_q)) begin
                            parity_error_d = 1'b1;
                        end
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        if (rx_s_q) begin
                            accept = 1'b1;
                        end else begin
                            frame_error_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        // A completed frame lands only if the holding register is free
        // (or being read this very cycle); otherwise it is dropped.
        if (accept) begin
            if (!data_ready_q || data_ack) begin
                data_out_d   = shift_q;
                data_ready_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Control, synchronizer and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            bit_idx_q      <= 3'd0;
            sync1_q        <= 1'b1;
            rx_s_q         <= 1'b1;
            prev_q         <= 1'b1;
            data_out_q     <= '0;
            data_ready_q   <= 1'b0;
            frame_error_q  <= 1'b0;
            overrun_q      <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            sync1_q        <= sync1_d;
            rx_s_q         <= rx_s_d;
            prev_q         <= prev_d;
            data_out_q     <= data_out_d;
            data_ready_q   <= data_ready_d;
            frame_error_q  <= frame_error_d;
            overrun_q      <= overrun_d;
            parity_error_q <= parity_error_d;
        end
    end

    // Shift register is pure datapath; it is fully rewritten before use.
    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

    assign data_out    = data_out_q;
    assign data_ready  = data_ready_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule
